// File: rtl/controle_varredura_pkg.sv
// Shared definitions for the 4-digit display scan controller:
// state encodings, the all-off anode pattern and an anode decode helper.
package controle_varredura_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHOW  = 2'b01,
    S_BLANK = 2'b10
  } state_t;

  // All digit enables inactive (anodes are active-low).
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Active-low one-hot anode pattern lighting digit idx.
  function automatic logic [3:0] an_on(input logic [1:0] idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/controle_varredura_if.sv
// Scan controller bus: enable/mask in, mux select and display drive out.
// The controller uses the slave view; whoever drives en/mask uses master.
interface controle_varredura_if;
  logic       en;
  logic [3:0] mask;
  logic [1:0] sel;
  logic [3:0] an;
  logic       blank;
  logic       frame;

  modport master (output en, mask, input sel, an, blank, frame);
  modport slave  (input en, mask, output sel, an, blank, frame);
endinterface

// File: rtl/controle_varredura_proximo_digito.sv
// Combinational digit picker. With incl=1 it returns the first enabled
// index starting at idx (idx, idx+1, ...); with incl=0 the first enabled
// index after idx (idx+1, ..., idx). wrap flags an advance that does not
// move to a higher index, i.e. the scan has come round again.
module proximo_digito (
  input  logic [1:0] idx,
  input  logic [3:0] mask,
  input  logic       incl,
  output logic [1:0] nxt,
  output logic       wrap
);

  logic [1:0] cand [4];

  // Candidate k is the k-th index visited in circular search order.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi] = idx + (incl ? 2'(gi) : 2'(gi + 1));
    end
  endgenerate

  // Earliest enabled candidate wins; scanning backwards lets it overwrite.
  always_comb begin
    nxt = idx;
    for (int k = 3; k >= 0; k--) begin
      if (mask[cand[k]]) begin
        nxt = cand[k];
      end
    end
    wrap = (mask != 4'b0000) && !incl && (nxt <= idx);
  end

endmodule

// File: rtl/controle_varredura.sv
// Scan controller for a 4-digit multiplexed display. Each enabled digit is
// lit for DIV_SHOW cycles, then all anodes are off for DIV_BLANK cycles
// before moving on; frame pulses for one cycle after each wrap-around.
module controle_varredura
  import controle_varredura_pkg::*;
#(
  parameter int DIV_SHOW  = 50000,
  parameter int DIV_BLANK = 500,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  controle_varredura_if.slave  bus
);

  // Terminal counts; the blank one is unused when blanking is disabled.
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV_SHOW - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((DIV_BLANK > 0) ? DIV_BLANK - 1 : 0);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       an_q, an_d;
  logic             blank_q, blank_d;
  logic             frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] first_idx, next_idx;
  logic       first_wrap, next_wrap;
  logic       active;

  // Entry from IDLE may light the current digit itself.
  proximo_digito u_first (
    .idx  (sel_q),
    .mask (bus.mask),
    .incl (1'b1),
    .nxt  (first_idx),
    .wrap (first_wrap)
  );

  // Advances always move past the current digit.
  proximo_digito u_next (
    .idx  (sel_q),
    .mask (bus.mask),
    .incl (1'b0),
    .nxt  (next_idx),
    .wrap (next_wrap)
  );

  assign active = bus.en && (bus.mask != 4'b0000);

  // Next-state, counter and output decode; outputs are computed here so
  // that they change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    an_d    = an_q;
    blank_d = blank_q;
    frame_d = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        an_d    = AN_OFF;
        blank_d = 1'b1;
        if (active) begin
          state_d = S_SHOW;
          sel_d   = first_idx;
          an_d    = an_on(first_idx);
          blank_d = 1'b0;
          cnt_d   = '0;
        end
      end

      S_SHOW: begin
        if (!active) begin
          state_d = S_IDLE;
          an_d    = AN_OFF;
          blank_d = 1'b1;
          cnt_d   = '0;
        end else if (!bus.mask[sel_q] || (cnt_q == SHOW_LAST)) begin
          cnt_d = '0;
          if (DIV_BLANK == 0) begin
            // No gap: hop straight to the next digit.
            sel_d   = next_idx;
            an_d    = an_on(next_idx);
            blank_d = 1'b0;
            frame_d = next_wrap;
          end else begin
            state_d = S_BLANK;
            an_d    = AN_OFF;
            blank_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_BLANK: begin
        if (!active) begin
          state_d = S_IDLE;
          an_d    = AN_OFF;
          blank_d = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          // next() is evaluated here so mask edits during the gap count.
          state_d = S_SHOW;
          sel_d   = next_idx;
          an_d    = an_on(next_idx);
          blank_d = 1'b0;
          frame_d = next_wrap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        an_d    = AN_OFF;
        blank_d = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset blanks the display at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= 2'b00;
      an_q    <= AN_OFF;
      blank_q <= 1'b1;
      frame_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      blank_q <= blank_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.an    = an_q;
  assign bus.blank = blank_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_controle_varredura.sv
// Bench for controle_varredura: one instance with DIV_SHOW=4/DIV_BLANK=2
// and one with DIV_BLANK=0. Expected outputs are queued as each cycle's
// stimulus is driven and popped once the clock edge has produced output.
module tb_controle_varredura;
  import controle_varredura_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  controle_varredura_if bus_a ();
  controle_varredura_if bus_b ();

  controle_varredura #(.DIV_SHOW(4), .DIV_BLANK(2), .CNT_W(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  controle_varredura #(.DIV_SHOW(4), .DIV_BLANK(0), .CNT_W(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] an;
    logic       blank;
    logic       frame;
  } obs_t;

  typedef struct {
    logic       en;
    logic [3:0] mask;
    obs_t       exp;
  } vec_t;

  obs_t  sb_q [$];
  string nm_q [$];
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic obs_t obs_of(input bit which);
    obs_t o;
    if (which) o = {bus_b.sel, bus_b.an, bus_b.blank, bus_b.frame};
    else       o = {bus_a.sel, bus_a.an, bus_a.blank, bus_a.frame};
    return o;
  endfunction

  function automatic obs_t show_obs(input logic [1:0] d, input logic f);
    logic [3:0] a;
    a = 4'b0001 << d;
    return {d, ~a, 1'b0, f};
  endfunction

  function automatic obs_t off_obs(input logic [1:0] d);
    return {d, 4'b1111, 1'b1, 1'b0};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got sel=%0d an=%b blank=%b frame=%b, required sel=%0d an=%b blank=%b frame=%b",
                  name, got.sel, got.an, got.blank, got.frame,
                  exp.sel, exp.an, exp.blank, exp.frame);
  endtask

  // One clock cycle: drive inputs, queue the expectation, compare after the edge.
  task automatic cyc(input bit which, input logic e, input logic [3:0] m,
                     input obs_t exp, input string name);
    obs_t  want;
    string nm;
    if (which) begin bus_b.en = e; bus_b.mask = m; end
    else       begin bus_a.en = e; bus_a.mask = m; end
    sb_q.push_back(exp);
    nm_q.push_back(name);
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    nm   = nm_q.pop_front();
    check(nm, obs_of(which), want);
  endtask

  // Timeline model of a steady scan: digits taken in circular order from
  // entry, each lit 4 cycles then blank_len cycles dark; frame on the first
  // lit cycle of a digit that is not above its predecessor.
  task automatic gen_scan(input bit which, input logic [3:0] m, input logic [1:0] entry,
                          input int blank_len, input int ncyc, input string name,
                          output logic [1:0] last_sel);
    logic [1:0] lst [4];
    logic [1:0] d, cur, prv;
    int n, period, slot, ph;
    obs_t e;
    n = 0;
    for (int j = 0; j < 4; j++) begin
      d = entry + 2'(j);
      if (m[d]) begin
        lst[n] = d;
        n++;
      end
    end
    period   = 4 + blank_len;
    last_sel = entry;
    for (int t = 0; t < ncyc; t++) begin
      slot = t / period;
      ph   = t % period;
      cur  = lst[slot % n];
      prv  = lst[(slot + n - 1) % n];
      if (ph < 4) e = show_obs(cur, (ph == 0) && (slot > 0) && (cur <= prv));
      else        e = off_obs(cur);
      cyc(which, 1'b1, m, e, $sformatf("%s_t%0d", name, t));
      last_sel = cur;
    end
  endtask

  vec_t idle_tab [3];
  vec_t drop_tab [10];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ls;

    idle_tab[0] = '{1'b0, 4'b1111, off_obs(2'd0)};
    idle_tab[1] = '{1'b1, 4'b0000, off_obs(2'd0)};
    idle_tab[2] = '{1'b1, 4'b0000, off_obs(2'd0)};

    // Enter on digit 1, drop mask[1] on counter cycle 1, advance to 2.
    drop_tab[0] = '{1'b1, 4'b0010, show_obs(2'd1, 1'b0)};
    drop_tab[1] = '{1'b1, 4'b1111, show_obs(2'd1, 1'b0)};
    drop_tab[2] = '{1'b1, 4'b1101, off_obs(2'd1)};
    drop_tab[3] = '{1'b1, 4'b1101, off_obs(2'd1)};
    drop_tab[4] = '{1'b1, 4'b1101, show_obs(2'd2, 1'b0)};
    drop_tab[5] = '{1'b1, 4'b1101, show_obs(2'd2, 1'b0)};
    drop_tab[6] = '{1'b1, 4'b1101, show_obs(2'd2, 1'b0)};
    drop_tab[7] = '{1'b1, 4'b1101, show_obs(2'd2, 1'b0)};
    drop_tab[8] = '{1'b1, 4'b1101, off_obs(2'd2)};
    drop_tab[9] = '{1'b0, 4'b1101, off_obs(2'd2)};

    reset      = 1'b1;
    bus_a.en   = 1'b0;
    bus_a.mask = 4'b0000;
    bus_b.en   = 1'b0;
    bus_b.mask = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_a", obs_of(1'b0), off_obs(2'd0));
    check("reset_b", obs_of(1'b1), off_obs(2'd0));

    for (int i = 0; i < 3; i++)
      cyc(1'b0, idle_tab[i].en, idle_tab[i].mask, idle_tab[i].exp, $sformatf("idle_%0d", i));

    gen_scan(1'b0, 4'b1111, 2'd0, 2, 30, "scan1111", ls);
    cyc(1'b0, 1'b0, 4'b1111, off_obs(ls), "stop1111");

    gen_scan(1'b0, 4'b0101, 2'd0, 2, 26, "scan0101", ls);
    cyc(1'b0, 1'b0, 4'b0101, off_obs(ls), "stop0101");

    cyc(1'b0, 1'b1, 4'b0000, off_obs(ls), "mask0_a");
    cyc(1'b0, 1'b1, 4'b0000, off_obs(ls), "mask0_b");
    gen_scan(1'b0, 4'b0100, 2'd2, 2, 14, "scan0100", ls);
    cyc(1'b0, 1'b1, 4'b0000, off_obs(2'd2), "show_to_idle_mask0");

    for (int i = 0; i < 10; i++)
      cyc(1'b0, drop_tab[i].en, drop_tab[i].mask, drop_tab[i].exp, $sformatf("drop_%0d", i));

    // Asynchronous reset in the middle of a dwell, away from any clock edge.
    cyc(1'b0, 1'b1, 4'b1111, show_obs(2'd2, 1'b0), "pre_reset_0");
    cyc(1'b0, 1'b1, 4'b1111, show_obs(2'd2, 1'b0), "pre_reset_1");
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", obs_of(1'b0), off_obs(2'd0));
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 1'b1, 4'b1111, show_obs(2'd0, 1'b0), "after_reset");
    bus_a.en = 1'b0;

    gen_scan(1'b1, 4'b1111, 2'd0, 0, 18, "noblank1111", ls);
    cyc(1'b1, 1'b0, 4'b1111, off_obs(ls), "noblank_stop");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
